// File: rtl/oc8051_irq_ctrl.sv
// Two-level 8051 interrupt controller: IE/IP SFRs, external pin synchronisers,
// priority arbitration and the request/acknowledge handshake with the core.
module oc8051_irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int VEC_STRIDE  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_addr,
  input  logic [7:0] rd_addr,
  input  logic [7:0] data_in,
  input  logic       bit_in,
  input  logic       wr,
  input  logic       wr_bit,
  input  logic       int0_n,
  input  logic       int1_n,
  input  logic       it0,
  input  logic       it1,
  input  logic       tf0,
  input  logic       tf1,
  input  logic       ri,
  input  logic       ti,
  input  logic       ack,
  input  logic       reti,
  output logic [7:0] data_out,
  output logic       int_req,
  output logic [7:0] int_vec,
  output logic       ie0,
  output logic       ie1,
  output logic       tf0_clr,
  output logic       tf1_clr,
  output logic [1:0] in_service
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [7:0] IE_ADDR = 8'hA8;
  localparam logic [7:0] IP_ADDR = 8'hB8;
  localparam logic [7:0] IE_MASK = 8'h9F;
  localparam logic [7:0] IP_MASK = 8'h1F;

  // ---------------------------------------------------------------- SFRs
  logic [7:0] ie_q, ip_q, ie_next, ip_next;
  logic       byte_wr, bit_wr;

  assign byte_wr = wr & ~wr_bit;
  assign bit_wr  = wr & wr_bit;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    ie_next = ie_q;
    ip_next = ip_q;
    if (byte_wr && wr_addr == IE_ADDR)
      ie_next = data_in;
    else if (bit_wr && wr_addr[7:3] == IE_ADDR[7:3])
      ie_next[wr_addr[2:0]] = bit_in;
    if (byte_wr && wr_addr == IP_ADDR)
      ip_next = data_in;
    else if (bit_wr && wr_addr[7:3] == IP_ADDR[7:3])
      ip_next[wr_addr[2:0]] = bit_in;
    ie_next = ie_next & IE_MASK;
    ip_next = ip_next & IP_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q <= 8'h00;
      ip_q <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      ie_q <= ie_next;
      ip_q <= ip_next;
    end
  end

  // Registered read port; a byte write to the address being read is forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 8'h00;
    end else if (byte_wr && wr_addr == rd_addr &&
                 (rd_addr == IE_ADDR || rd_addr == IP_ADDR)) begin
      data_out <= data_in;
    end else begin
      case (rd_addr)
        IE_ADDR: data_out <= ie_q;
        IP_ADDR: data_out <= ip_q;
        default: data_out <= 8'h00;
      endcase
    end
  end

  // ------------------------------------------------- pin synchronisers
  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic                   int0_s, int1_s, int0_s_d, int1_s_d;

  assign int0_s = sync0_q[SYNC_STAGES-1];
  assign int1_s = sync1_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q  <= '1;
      sync1_q  <= '1;
      int0_s_d <= 1'b1;
      int1_s_d <= 1'b1;
    end else begin
      sync0_q  <= {sync0_q[SYNC_STAGES-2:0], int0_n};
      sync1_q  <= {sync1_q[SYNC_STAGES-2:0], int1_n};
      int0_s_d <= int0_s;
      int1_s_d <= int1_s;
    end
  end

  // ---------------------------------------------------------- arbiter
  state_t     state_q;
  logic [2:0] req_idx_q, win_idx;
  logic       req_lvl_q, win_lvl;
  logic [4:0] src, pend, elig, hi_elig, pick;
  logic       allow_hi, allow_lo, ack_take;

  assign ack_take = (state_q == REQ) && ack;
  assign src      = {ri | ti, tf1, ie1, tf0, ie0};
  assign pend     = src & ie_q[4:0] & {5{ie_q[7]}};
  assign allow_hi = ~in_service[1];
  assign allow_lo = (in_service == 2'b00);
  assign elig     = pend & ((ip_q[4:0] & {5{allow_hi}}) | (~ip_q[4:0] & {5{allow_lo}}));
  assign hi_elig  = elig & ip_q[4:0];
  assign pick     = (|hi_elig) ? hi_elig : elig;
  assign win_lvl  = |hi_elig;

  always_comb begin
    win_idx = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (pick[i]) win_idx = 3'(i);
  end

  function automatic logic [7:0] vec_of(input logic [2:0] idx);
    return 8'h03 + 8'(VEC_STRIDE) * {5'b0, idx};
  endfunction

  // Edge flags set on a synchronised falling edge and clear when their vector
  // is acknowledged; in level mode they simply follow the inverted pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie0 <= 1'b0;
      ie1 <= 1'b0;
    end else begin
      if (it0) begin
        if (int0_s_d && !int0_s)                ie0 <= 1'b1;
        else if (ack_take && req_idx_q == 3'd0) ie0 <= 1'b0;
      end else begin
        ie0 <= ~int0_s;
      end
      if (it1) begin
        if (int1_s_d && !int1_s)                ie1 <= 1'b1;
        else if (ack_take && req_idx_q == 3'd2) ie1 <= 1'b0;
      end else begin
        ie1 <= ~int1_s;
      end
    end
  end

  // -------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      int_req   <= 1'b0;
      int_vec   <= 8'h00;
      req_idx_q <= 3'd0;
      req_lvl_q <= 1'b0;
      tf0_clr   <= 1'b0;
      tf1_clr   <= 1'b0;
    end else begin
      tf0_clr <= 1'b0;
      tf1_clr <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|elig) begin
            state_q   <= REQ;
            int_req   <= 1'b1;
            int_vec   <= vec_of(win_idx);
            req_idx_q <= win_idx;
            req_lvl_q <= win_lvl;
          end
        end
        REQ: begin
          // No preemption here: a better source waits until this one is acked.
          if (ack) begin
            state_q <= IDLE;
            int_req <= 1'b0;
            tf0_clr <= (req_idx_q == 3'd1);
            tf1_clr <= (req_idx_q == 3'd3);
          end else if (!pend[req_idx_q]) begin
            state_q <= IDLE;
            int_req <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // reti retires the highest active level seen before this edge; an
  // acknowledge in the same cycle still marks its own level.
  logic [1:0] isv_next;

  always_comb begin
    isv_next = in_service;
    if (reti) begin
      if (in_service[1])      isv_next[1] = 1'b0;
      else if (in_service[0]) isv_next[0] = 1'b0;
    end
    if (ack_take) isv_next[req_lvl_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_service <= 2'b00;
    else        in_service <= isv_next;
  end

endmodule

// File: tb/tb_oc8051_irq_ctrl.sv
// Self-checking bench for oc8051_irq_ctrl: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the controller.
module tb_oc8051_irq_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_addr, rd_addr, data_in;
  logic       bit_in, wr, wr_bit, int0_n, int1_n, it0, it1;
  logic       tf0, tf1, ri, ti, ack, reti;
  logic [7:0] data_out, int_vec;
  logic       int_req, ie0, ie1, tf0_clr, tf1_clr;
  logic [1:0] in_service;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  oc8051_irq_ctrl #(.SYNC_STAGES(S), .VEC_STRIDE(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .data_in(data_in), .bit_in(bit_in), .wr(wr), .wr_bit(wr_bit),
    .int0_n(int0_n), .int1_n(int1_n), .it0(it0), .it1(it1),
    .tf0(tf0), .tf1(tf1), .ri(ri), .ti(ti), .ack(ack), .reti(reti),
    .data_out(data_out), .int_req(int_req), .int_vec(int_vec),
    .ie0(ie0), .ie1(ie1), .tf0_clr(tf0_clr), .tf1_clr(tf1_clr),
    .in_service(in_service)
  );

  // ------------------------------------------------ reference model
  logic [7:0] m_ie, m_ip, m_dout;
  bit         m_ie0, m_ie1, m_req, m_clr0, m_clr1;
  bit   [1:0] m_isv;
  int         m_idx, m_lvl;
  bit         q0[$], q1[$];   // pin samples, newest first

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ie = 8'h00; m_ip = 8'h00; m_dout = 8'h00;
    m_ie0 = 0; m_ie1 = 0; m_req = 0; m_clr0 = 0; m_clr1 = 0;
    m_isv = 2'b00; m_idx = 0; m_lvl = 0;
    q0.delete(); q1.delete();
    repeat (S + 1) begin q0.push_front(1'b1); q1.push_front(1'b1); end
  endtask

  function automatic bit level_allowed(input int lvl);
    if (m_isv == 2'b00) return 1'b1;
    if (m_isv == 2'b01) return (lvl == 1);
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit   src[5];
    bit   pend[5];
    int   w, wl;
    bit   take, n_ie0, n_ie1, n_req;
    bit   [1:0] n_isv;
    logic [7:0] n_ie, n_ip, n_dout;
    int   n_idx, n_lvl;
    src = '{m_ie0, tf0, m_ie1, tf1, ri | ti};
    for (int i = 0; i < 5; i++) pend[i] = src[i] && m_ie[i] && m_ie[7];
    w = -1; wl = 0;
    for (int lvl = 1; lvl >= 0; lvl--)
      for (int i = 0; i < 5; i++)
        if (w < 0 && pend[i] && int'(m_ip[i]) == lvl && level_allowed(lvl)) begin
          w = i; wl = lvl;
        end
    take = m_req && ack;
    n_isv = m_isv;
    if (reti) begin
      if (n_isv[1]) n_isv[1] = 1'b0;
      else if (n_isv[0]) n_isv[0] = 1'b0;
    end
    if (take) n_isv[m_lvl] = 1'b1;
    if (it0) n_ie0 = (q0[S] && !q0[S-1]) ? 1'b1 : ((take && m_idx == 0) ? 1'b0 : m_ie0);
    else     n_ie0 = !q0[S-1];
    if (it1) n_ie1 = (q1[S] && !q1[S-1]) ? 1'b1 : ((take && m_idx == 2) ? 1'b0 : m_ie1);
    else     n_ie1 = !q1[S-1];
    n_req = m_req; n_idx = m_idx; n_lvl = m_lvl;
    if (!m_req) begin
      if (w >= 0) begin n_req = 1; n_idx = w; n_lvl = wl; end
    end else if (take || !pend[m_idx]) begin
      n_req = 0;
    end
    if (wr && !wr_bit && wr_addr == rd_addr && (rd_addr == 8'hA8 || rd_addr == 8'hB8))
      n_dout = data_in;
    else
      n_dout = (rd_addr == 8'hA8) ? m_ie : (rd_addr == 8'hB8) ? m_ip : 8'h00;
    n_ie = m_ie; n_ip = m_ip;
    if (wr && !wr_bit) begin
      if (wr_addr == 8'hA8) n_ie = data_in & 8'h9F;
      if (wr_addr == 8'hB8) n_ip = data_in & 8'h1F;
    end
    if (wr && wr_bit) begin
      if ({wr_addr[7:3], 3'b000} == 8'hA8) begin n_ie[wr_addr[2:0]] = bit_in; n_ie &= 8'h9F; end
      if ({wr_addr[7:3], 3'b000} == 8'hB8) begin n_ip[wr_addr[2:0]] = bit_in; n_ip &= 8'h1F; end
    end
    m_clr0 = take && m_idx == 1;
    m_clr1 = take && m_idx == 3;
    m_isv = n_isv; m_ie0 = n_ie0; m_ie1 = n_ie1;
    m_req = n_req; m_idx = n_idx; m_lvl = n_lvl;
    m_dout = n_dout; m_ie = n_ie; m_ip = n_ip;
    q0.push_front(int0_n); void'(q0.pop_back());
    q1.push_front(int1_n); void'(q1.pop_back());
  endtask

  task automatic compare_all();
    check("int_req", {7'b0, int_req}, {7'b0, m_req});
    if (m_req) check("int_vec", int_vec, 8'(3 + m_idx * 8));
    check("in_service", {6'b0, in_service}, {6'b0, m_isv});
    check("ie0", {7'b0, ie0}, {7'b0, m_ie0});
    check("ie1", {7'b0, ie1}, {7'b0, m_ie1});
    check("tf0_clr", {7'b0, tf0_clr}, {7'b0, m_clr0});
    check("tf1_clr", {7'b0, tf1_clr}, {7'b0, m_clr1});
    check("data_out", data_out, m_dout);
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later,
  // then the single-cycle strobes are released.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    ack = 0; reti = 0; wr = 0;
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    wr = 1; wr_bit = 0; wr_addr = a; data_in = d;
    tick();
  endtask

  task automatic write_bit(input logic [7:0] a, input logic b);
    wr = 1; wr_bit = 1; wr_addr = a; bit_in = b;
    tick();
  endtask

  task automatic wait_req(input int bound, output int n);
    n = 0;
    while (!int_req && n < bound) begin tick(); n++; end
    check("req_timeout", {7'b0, int_req}, 8'h01);
  endtask

  initial begin
    int n;
    rst_n = 0; wr_addr = 0; rd_addr = 8'hA8; data_in = 0; bit_in = 0;
    wr = 0; wr_bit = 0; int0_n = 1; int1_n = 1; it0 = 0; it1 = 0;
    tf0 = 0; tf1 = 0; ri = 0; ti = 0; ack = 0; reti = 0;
    model_reset();
    #12;
    check("rst_int_req", {7'b0, int_req}, 8'h00);
    check("rst_int_vec", int_vec, 8'h00);
    compare_all();
    @(negedge clk); rst_n = 1;

    // tf0 request, acknowledge, hardware clear
    write_byte(8'hA8, 8'h82);
    tf0 = 1; tick();
    check("t1_req", {7'b0, int_req}, 8'h01);
    check("t1_vec", int_vec, 8'h0B);
    ack = 1; tick();
    check("t1_clr", {7'b0, tf0_clr}, 8'h01);
    check("t1_isv", {6'b0, in_service}, 8'h01);
    tf0 = 0; tick();
    check("t1_clr_pulse", {7'b0, tf0_clr}, 8'h00);
    reti = 1; tick();
    check("t1_reti", {6'b0, in_service}, 8'h00);

    // simultaneous tf0/tf1: index order, then tf1 after reti
    write_byte(8'hA8, 8'h8A);
    tf0 = 1; tf1 = 1; tick();
    check("t2_vec0", int_vec, 8'h0B);
    ack = 1; tick();
    tf0 = 0; tick(); tick();
    check("t2_blocked", {7'b0, int_req}, 8'h00);
    reti = 1; tick(); tick();
    check("t2_vec1", int_vec, 8'h1B);
    ack = 1; tick();
    tf1 = 0; reti = 1; tick(); tick();

    // high-priority tf1 preempts in-service tf0
    write_byte(8'hB8, 8'h08);
    tf0 = 1; tick();
    ack = 1; tick();
    tf0 = 0; tf1 = 1; tick();
    check("t3_vec", int_vec, 8'h1B);
    ack = 1; tick();
    check("t3_isv11", {6'b0, in_service}, 8'h03);
    tf1 = 0; reti = 1; tick();
    check("t3_isv01", {6'b0, in_service}, 8'h01);
    reti = 1; tick();
    check("t3_isv00", {6'b0, in_service}, 8'h00);
    write_byte(8'hB8, 8'h00);

    // external int0: edge mode latency, ack clear, then level mode
    it0 = 1;
    write_byte(8'hA8, 8'h81);
    int0_n = 0;
    wait_req(12, n);
    check("t4_latency", 8'(n), 8'(S + 2));
    check("t4_vec", int_vec, 8'h03);
    ack = 1; tick(); tick();
    check("t4_ie0_clr", {7'b0, ie0}, 8'h00);
    it0 = 0; tick(); tick(); tick();
    check("t4_level_blocked", {7'b0, int_req}, 8'h00);
    reti = 1; tick();
    wait_req(6, n);
    check("t4_rereq_vec", int_vec, 8'h03);
    ack = 1; tick();
    int0_n = 1; repeat (4) tick();
    reti = 1; tick(); tick();

    // IE.7 bit clear drops a pending request; read bypass
    write_byte(8'hA8, 8'h82);
    tf0 = 1; tick();
    write_bit(8'hAF, 1'b0);
    tick();
    check("t5_drop", {7'b0, int_req}, 8'h00);
    tf0 = 0; rd_addr = 8'hA8;
    write_byte(8'hA8, 8'h93);
    check("t5_bypass", data_out, 8'h93);
    tick();
    check("t5_readback", data_out, 8'h93);
    write_byte(8'hA8, 8'h00);

    // asynchronous reset during a request
    write_byte(8'hA8, 8'h82);
    tf0 = 1; tick();
    check("t6_req", {7'b0, int_req}, 8'h01);
    @(negedge clk); rst_n = 0; #1;
    model_reset();
    check("t6_async_drop", {7'b0, int_req}, 8'h00);
    compare_all();
    tf0 = 0;
    @(negedge clk); rst_n = 1;
    repeat (5) tick();
    check("t6_quiet", {7'b0, int_req}, 8'h00);

    // randomized run
    write_byte(8'hA8, 8'h9F);
    write_byte(8'hB8, 8'($urandom_range(0, 31)));
    for (int k = 0; k < 800; k++) begin
      tf0  = ($urandom_range(0, 3) == 0);
      tf1  = ($urandom_range(0, 3) == 0);
      ri   = ($urandom_range(0, 9) == 0);
      ti   = ($urandom_range(0, 9) == 0);
      ack  = ($urandom_range(0, 2) == 0);
      reti = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 7) == 0) int0_n = ~int0_n;
      if ($urandom_range(0, 7) == 0) int1_n = ~int1_n;
      if ($urandom_range(0, 49) == 0) it0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) it1 = 1'($urandom_range(0, 1));
      wr      = ($urandom_range(0, 9) == 0);
      wr_bit  = 1'($urandom_range(0, 1));
      bit_in  = 1'($urandom_range(0, 1));
      data_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) data_in[7] = 1'b1;
      case ($urandom_range(0, 2))
        0:       wr_addr = 8'hA8;
        1:       wr_addr = 8'hB8;
        default: wr_addr = 8'h90;
      endcase
      if (wr_bit) wr_addr[2:0] = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       rd_addr = 8'hA8;
        1:       rd_addr = 8'hB8;
        default: rd_addr = 8'h90;
      endcase
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
